// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit hex 7-segment driver: guard blanking, leading-zero blanking, tear-free double buffer.
// Latency: seg/an registered, 1 clock behind (cnt, idx, active, lz_en); no backpressure, load is a fire-and-forget strobe.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_digits_in,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_load,
    input  logic                    i_lz_en,
    input  logic                    i_enable,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow_dig;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [4*NUM_DIGITS-1:0] r_active_dig;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic                    r_pending;

    logic                    w_boundary;
    logic                    w_zero_run;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic [3:0]              w_cur_dig;
    logic                    w_cur_dp;
    logic                    w_cur_sup;
    logic [7:0]              w_seg_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;  default: glyph = 7'h71;
        endcase
    endfunction

    assign w_boundary = i_enable && (r_cnt == CNT_LAST) && (r_idx == IDX_LAST);

    always_comb begin
        w_zero_run = i_lz_en;
        w_sup      = '0;
        w_cur_dig  = 4'h0;
        w_cur_dp   = 1'b0;
        w_cur_sup  = 1'b0;
        // Walk from the most significant digit; blanking stops at the first nonzero nibble.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_active_dig[4*i +: 4] != 4'h0) w_zero_run = 1'b0;
            w_sup[i] = w_zero_run && (i != 0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_dig = r_active_dig[4*i +: 4];
                w_cur_dp  = r_active_dp[i];
                w_cur_sup = w_sup[i];
            end
        end
        w_seg_nxt = 8'h00;
        w_an_nxt  = '0;
        if (i_enable && (r_cnt >= GUARD_C)) begin
            w_an_nxt  = NUM_DIGITS'(1) << r_idx;
            w_seg_nxt = {w_cur_dp, w_cur_sup ? 7'h00 : glyph(w_cur_dig)};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_active_dig <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
            o_frame_done <= 1'b0;
            o_seg        <= {8{SEG_ACTIVE_LOW}};
            o_an         <= {NUM_DIGITS{AN_ACTIVE_LOW}};
        end else begin
            o_seg        <= w_seg_nxt ^ {8{SEG_ACTIVE_LOW}};
            o_an         <= w_an_nxt ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
            o_frame_done <= w_boundary && (r_pending || i_load);

            if (!i_enable) begin
                r_cnt <= '0;
                r_idx <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (i_load) begin
                r_shadow_dig <= i_digits_in;
                r_shadow_dp  <= i_dp_in;
            end
            // A load landing on the boundary skips the shadow and takes effect this frame.
            if (w_boundary && i_load) begin
                r_active_dig <= i_digits_in;
                r_active_dp  <= i_dp_in;
                r_pending    <= 1'b0;
            end else if (w_boundary && r_pending) begin
                r_active_dig <= r_shadow_dig;
                r_active_dp  <= r_shadow_dp;
                r_pending    <= 1'b0;
            end else if (i_load) begin
                r_pending    <= 1'b1;
            end
        end
    end

endmodule
